sine_addr_gen: RTL
==================

Name: sine_addr_gen

Overview:
- Phase-accumulator address generator that feeds the dual-port sine ROM in the signal-generator datapath.
- Produces two ROM read addresses each sample tick:
  - addr1: the base phase.
  - addr2: the base phase plus a programmable phase offset.
- Provides valid strobes aligned to both the address outputs and the ROM's 1-cycle registered read data.
- Sample rate is set by an internal clock prescaler.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; width of addr1, addr2 and offset.
- ACC_WIDTH, 16, phase accumulator width; must be >= ADDRESS_WIDTH.
- DIV_WIDTH, 8, prescaler divide-ratio width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  run enable; low freezes accumulator and prescaler.
- sync  in  1  synchronous phase reset pulse.
- incr  in  ACC_WIDTH  phase increment per tick (frequency word).
- offset  in  ADDRESS_WIDTH  phase offset of addr2 relative to addr1.
- div  in  DIV_WIDTH  sample tick every div cycles; 0 treated as 1.
- sweep_start  in  1  start frequency sweep (used only with SWEEP_EN).
- sweep_step  in  ACC_WIDTH  increment added per tick during sweep.
- sweep_max  in  ACC_WIDTH  sweep end increment.
- addr1  out  ADDRESS_WIDTH  ROM address 1 (registered).
- addr2  out  ADDRESS_WIDTH  ROM address 2 (registered).
- addr_valid  out  1  addr1/addr2 updated this cycle.
- data_valid  out  1  addr_valid delayed 1 cycle; qualifies ROM dout1/dout2.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  1-cycle pulse at sweep completion.

Behaviour:
- Reset (rst=0 at a clk edge):
  - acc=0, div_cnt=0, addr1=0, addr2=0.
  - addr_valid=0, data_valid=0, sweep_busy=0, sweep_done=0.
  - Sweep FSM returns to IDLE.
- Prescaler, when en=1:
  - div_cnt counts 0..max(div,1)-1 and wraps.
  - tick is asserted when div_cnt==max(div,1)-1.
  - div=0 or div=1 gives a tick every cycle.
  - A change to div takes effect from the next wrap.
- Accumulator:
  - On a tick edge, acc <= acc + eff_incr, modulo 2^ACC_WIDTH.
  - eff_incr = incr, or cur_incr while sweeping.
  - incr and offset are sampled at the tick edge.
- Addresses, at the same tick edge:
  - addr1 <= top ADDRESS_WIDTH bits of the new acc.
  - addr2 <= that value + offset, modulo 2^ADDRESS_WIDTH (wraps, no saturation).
- Valid pipeline:
  - addr_valid is high for the cycle following each tick edge.
  - data_valid is addr_valid registered once, matching the ROM's 1-cycle read latency.
- en=0:
  - No ticks; acc, div_cnt and the addresses hold.
  - addr_valid=0; data_valid still drains the pending pulse.
- sync=1 (priority over en and tick; below rst):
  - acc=0, div_cnt=0, addr1=0, addr2=offset.
  - addr_valid=0 the next cycle.
  - An active sweep aborts to IDLE with no sweep_done.
- Priority order: rst > sync > tick.

Optional Feature:
- Macro: SINE_ADDR_GEN_SWEEP_EN.
- Defined — sweep FSM with states IDLE, SWEEP:
  - IDLE -> SWEEP on sweep_start=1: cur_incr <= incr, sweep_busy=1.
  - In SWEEP, each tick uses cur_incr, then cur_incr <= cur_incr + sweep_step.
  - If cur_incr + sweep_step >= sweep_max, or the sum overflows ACC_WIDTH: cur_incr <= sweep_max, and the FSM moves to IDLE after that tick.
  - On that transition, sweep_done pulses 1 cycle and sweep_busy drops.
  - sweep_start while in SWEEP is ignored.
  - sweep_step=0 never terminates until sync or rst.
- Not defined:
  - sweep_* inputs are ignored; sweep_busy=0, sweep_done=0.
  - eff_incr is always incr.

Decomposition:
- Package sine_gen_pkg:
  - Default ADDRESS_WIDTH and ACC_WIDTH localparams.
  - sweep_state_t enum {IDLE, SWEEP}.
- One natural sub-module, tick_prescaler: div_cnt and tick generation.
- Accumulator, address registers and the valid pipeline stay in the top level.

Test Plan:
- Reset: hold rst=0 for 2 cycles with en=1 and incr=0x0100 -> all outputs 0; first tick occurs only after rst=1.
- Free-run: incr=0x0100, div=0, offset=0, en=1 -> addr1 steps 1,2,3,… each cycle; wraps 255->0 after 256 ticks; addr_valid continuously 1; data_valid lags by 1 cycle.
- Offset wrap: offset=64 -> addr2==(addr1+64) mod 256; e.g. addr1=200 gives addr2=8.
- Prescaler and freeze: div=3 -> addr_valid pulses 1 cycle in 3. Dropping en for 5 cycles -> addr1 unchanged, no addr_valid.
- Sync mid-run: sync=1 while addr1=0x37 and offset=0x10 -> next cycle addr1=0x00, addr2=0x10, addr_valid=0; the following tick gives addr1=0x01.
- Sweep (SINE_ADDR_GEN_SWEEP_EN): incr=0x0100, sweep_step=0x0100, sweep_max=0x0400, div=0 -> acc increments are 0x100, 0x200, 0x300, 0x400; sweep_done pulses once; afterwards eff_incr reverts to incr=0x0100.

Source files
------------

// File: rtl/sine_gen_pkg.sv
// Shared defaults and sweep FSM state type for the sine address generator.
package sine_gen_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_ACC_WIDTH     = 16;
    localparam int DEF_DIV_WIDTH     = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Sample-tick prescaler: ticks once every max(div,1) enabled cycles.
// The divide ratio is latched at each wrap so a new div starts cleanly.
module tick_prescaler #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic [DIV_WIDTH-1:0] lim_q;
    logic [DIV_WIDTH-1:0] lim_d;
    logic [DIV_WIDTH-1:0] div_eff_s;
    logic                 wrap_s;

    assign div_eff_s = (div == {DIV_WIDTH{1'b0}}) ? ONE : div;
    assign wrap_s    = en && (div_cnt_q == (lim_q - ONE));
    assign tick      = wrap_s && !clr;

    // Next count and latched limit; clear outranks the wrap.
    always_comb begin
        div_cnt_d = div_cnt_q;
        lim_d     = lim_q;
        if (clr) begin
            div_cnt_d = {DIV_WIDTH{1'b0}};
            lim_d     = div_eff_s;
        end else if (wrap_s) begin
            div_cnt_d = {DIV_WIDTH{1'b0}};
            lim_d     = div_eff_s;
        end else if (en) begin
            div_cnt_d = div_cnt_q + ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= {DIV_WIDTH{1'b0}};
            lim_q     <= div_eff_s;
        end else begin
            div_cnt_q <= div_cnt_d;
            lim_q     <= lim_d;
        end
    end

endmodule

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator for the dual-port sine ROM.
// Optional frequency sweep is built when SINE_ADDR_GEN_SWEEP_EN is defined.
module sine_addr_gen
    import sine_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int DIV_WIDTH     = DEF_DIV_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic                     sweep_start,
    input  logic [ACC_WIDTH-1:0]     sweep_step,
    input  logic [ACC_WIDTH-1:0]     sweep_max,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     addr_valid,
    output logic                     data_valid,
    output logic                     sweep_busy,
    output logic                     sweep_done
);

    logic                     tick_s;
    logic [ACC_WIDTH-1:0]     eff_incr_s;
    logic [ACC_WIDTH-1:0]     acc_sum_s;
    logic [ADDRESS_WIDTH-1:0] addr1_nxt_s;
    logic [ACC_WIDTH-1:0]     acc_q;
    logic [ACC_WIDTH-1:0]     acc_d;
    logic [ADDRESS_WIDTH-1:0] addr1_q;
    logic [ADDRESS_WIDTH-1:0] addr1_d;
    logic [ADDRESS_WIDTH-1:0] addr2_q;
    logic [ADDRESS_WIDTH-1:0] addr2_d;
    logic                     addr_valid_q;
    logic                     addr_valid_d;
    logic                     data_valid_q;
    logic                     data_valid_d;

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (sync),
        .div  (div),
        .tick (tick_s)
    );

    assign acc_sum_s   = acc_q + eff_incr_s;
    assign addr1_nxt_s = acc_sum_s[ACC_WIDTH-1 -: ADDRESS_WIDTH];

`ifdef SINE_ADDR_GEN_SWEEP_EN
    sweep_state_t         state_q;
    sweep_state_t         state_d;
    logic [ACC_WIDTH-1:0] cur_incr_q;
    logic [ACC_WIDTH-1:0] cur_incr_d;
    logic                 sat_q;
    logic                 sat_d;
    logic                 done_q;
    logic                 done_d;
    logic [ACC_WIDTH:0]   step_sum_s;

    assign step_sum_s = {1'b0, cur_incr_q} + {1'b0, sweep_step};
    assign eff_incr_s = (state_q == SWEEP) ? cur_incr_q : incr;

    // Sweep FSM; sat marks that sweep_max is loaded and the next tick is the last.
    always_comb begin
        state_d    = state_q;
        cur_incr_d = cur_incr_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
        if (sync) begin
            state_d = IDLE;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        state_d    = SWEEP;
                        cur_incr_d = incr;
                        sat_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SWEEP: begin
                    if (!tick_s) begin
                        state_d = SWEEP;
                    end else if (sat_q) begin
                        state_d = IDLE;
                        sat_d   = 1'b0;
                        done_d  = 1'b1;
                    end else if (step_sum_s[ACC_WIDTH] ||
                                 (step_sum_s[ACC_WIDTH-1:0] >= sweep_max)) begin
                        cur_incr_d = sweep_max;
                        sat_d      = 1'b1;
                    end else begin
                        cur_incr_d = step_sum_s[ACC_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_incr_q <= {ACC_WIDTH{1'b0}};
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_incr_q <= cur_incr_d;
            sat_q      <= sat_d;
            done_q     <= done_d;
        end
    end

    assign sweep_busy = (state_q == SWEEP);
    assign sweep_done = done_q;
`else
    logic unused_sweep_s;

    assign unused_sweep_s = ^{sweep_start, sweep_step, sweep_max};
    assign eff_incr_s     = incr;
    assign sweep_busy     = 1'b0;
    assign sweep_done     = 1'b0;
`endif

    // Accumulator, address and valid next-state; sync outranks the tick.
    always_comb begin
        acc_d        = acc_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        addr_valid_d = 1'b0;
        data_valid_d = addr_valid_q;
        if (sync) begin
            acc_d   = {ACC_WIDTH{1'b0}};
            addr1_d = {ADDRESS_WIDTH{1'b0}};
            addr2_d = offset;
        end else if (tick_s) begin
            acc_d        = acc_sum_s;
            addr1_d      = addr1_nxt_s;
            addr2_d      = addr1_nxt_s + offset;
            addr_valid_d = 1'b1;
        end else begin
            addr_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q        <= {ACC_WIDTH{1'b0}};
            addr1_q      <= {ADDRESS_WIDTH{1'b0}};
            addr2_q      <= {ADDRESS_WIDTH{1'b0}};
            addr_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            addr_valid_q <= addr_valid_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign addr_valid = addr_valid_q;
    assign data_valid = data_valid_q;

endmodule
